// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: data width, opcode constants,
// FSM state encoding and the latched command record.
package alu_sequencer_pkg;

    localparam int unsigned DW = 16;

    localparam logic [2:0] OPC_NEG = 3'b000;
    localparam logic [2:0] OPC_INC = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_AVG = 3'b011;
    localparam logic [2:0] OPC_AND = 3'b100;
    localparam logic [2:0] OPC_OR  = 3'b101;
    localparam logic [2:0] OPC_CAT = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } state_t;

    typedef struct packed {
        logic [2:0] opc;
        logic [1:0] dst;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic       cin;
    } cmd_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, register-load, downstream-ALU and result signals of the sequencer.
// slave is the sequencer side; master is the driver/ALU environment side.
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_opc;
    logic [1:0]    cmd_dst;
    logic [1:0]    cmd_srca;
    logic [1:0]    cmd_srcb;
    logic          cmd_cin;

    logic          ld_en;
    logic [1:0]    ld_idx;
    logic [DW-1:0] ld_data;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_c;
    logic [3:0]    alu_opc;
    logic [DW-1:0] alu_w;
    logic          alu_zer;
    logic          alu_neg;

    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_zer;
    logic          res_neg;

    modport slave (
        input  cmd_valid, cmd_opc, cmd_dst, cmd_srca, cmd_srcb, cmd_cin,
        input  ld_en, ld_idx, ld_data,
        input  alu_w, alu_zer, alu_neg,
        output cmd_ready,
        output alu_a, alu_b, alu_c, alu_opc,
        output res_valid, res_data, res_zer, res_neg
    );

    modport master (
        output cmd_valid, cmd_opc, cmd_dst, cmd_srca, cmd_srcb, cmd_cin,
        output ld_en, ld_idx, ld_data,
        output alu_w, alu_zer, alu_neg,
        input  cmd_ready,
        input  alu_a, alu_b, alu_c, alu_opc,
        input  res_valid, res_data, res_zer, res_neg
    );

endinterface

// File: rtl/alu_regfile.sv
// 4 x DW register file: two combinational read ports, one synchronous write
// port, cleared by the asynchronous reset.
module alu_regfile
    import alu_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [1:0]    widx,
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    ra_idx,
    input  logic [1:0]    rb_idx,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data
);

    logic [DW-1:0] regs [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[widx] <= wdata;
        end
    end

    always_comb begin
        ra_data = regs[ra_idx];
        rb_data = regs[rb_idx];
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state command sequencer around an external ALU: accept, read operands,
// execute, write back. One command every four cycles.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    alu_sequencer_if.slave bus
);

    state_t        state, state_nx;
    cmd_t          cmd_q;
    logic [DW-1:0] opa_q, opb_q;
    logic [DW-1:0] res_q;
    logic          zer_q, neg_q;
    logic          ready;
    logic          accept;

    logic [DW-1:0] rd_a, rd_b;
    logic          rf_we;
    logic [1:0]    rf_widx;
    logic [DW-1:0] rf_wdata;

    // Gated with rst_n so the handshake stays closed while reset is held.
    assign ready  = (state == IDLE) && rst_n;
    assign accept = ready && bus.cmd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.cmd_ready = ready;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_c     = 1'b0;
        bus.alu_opc   = '0;
        bus.res_valid = 1'b0;
        case (state)
            IDLE:  if (accept) state_nx = READ;
            READ:  state_nx = EXEC;
            EXEC: begin
                state_nx    = WRITE;
                bus.alu_a   = opa_q;
                bus.alu_b   = opb_q;
                bus.alu_c   = cmd_q.cin;
                bus.alu_opc = {1'b0, cmd_q.opc};
            end
            WRITE: begin
                state_nx      = IDLE;
                bus.res_valid = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result registers capture the ALU at the end of EXEC, so res_data is
    // already current while res_valid is high in WRITE and feeds the write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            zer_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= '{opc:  bus.cmd_opc,
                           dst:  bus.cmd_dst,
                           srca: bus.cmd_srca,
                           srcb: bus.cmd_srcb,
                           cin:  bus.cmd_cin};
            end
            if (state == READ) begin
                opa_q <= rd_a;
                opb_q <= rd_b;
            end
            if (state == EXEC) begin
                res_q <= bus.alu_w;
                zer_q <= bus.alu_zer;
                neg_q <= bus.alu_neg;
            end
        end
    end

    assign bus.res_data = res_q;
    assign bus.res_zer  = zer_q;
    assign bus.res_neg  = neg_q;

    always_comb begin
        rf_we    = (state == WRITE) || ((state == IDLE) && bus.ld_en);
        rf_widx  = (state == WRITE) ? cmd_q.dst : bus.ld_idx;
        rf_wdata = (state == WRITE) ? res_q : bus.ld_data;
    end

    alu_regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .widx    (rf_widx),
        .wdata   (rf_wdata),
        .ra_idx  (cmd_q.srca),
        .rb_idx  (cmd_q.srcb),
        .ra_data (rd_a),
        .rb_data (rd_b)
    );

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous, active-low reset).
REQ-002 cmd_valid input 1 SHALL mean a command is offered.
REQ-003 cmd_ready output 1 SHALL mean the block accepts a command this cycle.
REQ-004 cmd_opc input 3 SHALL carry the ALU opcode, 000..110.
REQ-005 cmd_dst, cmd_srca and cmd_srcb inputs 2 each SHALL carry register indices 0..3.
REQ-006 cmd_cin input 1 SHALL carry the carry-in for opcode 010.
REQ-007 ld_en input 1, ld_idx input 2 and ld_data input 16 SHALL form the direct register-load port.
REQ-008 alu_a and alu_b outputs 16, alu_c output 1 and alu_opc output 4 SHALL be the operands driven to the downstream ALU.
REQ-009 alu_w input 16, alu_zer input 1 and alu_neg input 1 SHALL be the ALU result and flags.
REQ-010 res_valid output 1 SHALL be a one-cycle pulse marking a written-back result.
REQ-011 res_data output 16, res_zer output 1 and res_neg output 1 SHALL carry the latched result and flags.

Function
REQ-012 The FSM SHALL have states IDLE, READ, EXEC and WRITE, taking the path IDLE->READ->EXEC->WRITE->IDLE with one cycle per state.
REQ-013 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-014 On acceptance, opc, dst, srca, srcb and cin SHALL be latched into a command register, and later changes on cmd_* inputs SHALL be ignored.
REQ-015 In READ, regs[srca] and regs[srcb] SHALL be latched into operand registers; srca=srcb SHALL be legal.
REQ-016 In EXEC, the block SHALL drive alu_a/alu_b from the operand registers, alu_opc={1'b0,opc} and alu_c=cin, and SHALL sample alu_w, alu_zer and alu_neg at the end of the cycle.
REQ-017 Outside EXEC, alu_a, alu_b, alu_c and alu_opc SHALL be 0.
REQ-018 In WRITE, regs[dst] SHALL be set to the sampled result, res_data/res_zer/res_neg SHALL be updated, and res_valid=1 for exactly that cycle.
REQ-019 Latency SHALL be fixed: a command accepted at edge N gives res_valid high in cycle N+3, and the next command is acceptable at edge N+4.
REQ-020 Back-to-back commands SHALL be allowed, with cmd_valid held high giving one command per 4 cycles.
REQ-021 dst equal to srca or srcb SHALL be legal; operands come from pre-write values and the register holds the new value afterwards.
REQ-022 ld_en=1 SHALL write ld_data into regs[ld_idx] only in IDLE; in other states ld_en SHALL be ignored.
REQ-023 If ld_en=1 and command acceptance fall in the same IDLE cycle, the load SHALL complete first, and READ in the next cycle SHALL observe the loaded value.
REQ-024 Opcode 111 SHALL be accepted and sequenced normally: the ALU returns 0 and res_zer=1.
REQ-025 res_data, res_zer and res_neg SHALL hold their value until the next WRITE.
REQ-026 All datapath arithmetic SHALL be in the ALU; the block SHALL only route and register 16-bit values, with no width extension or truncation.

Reset
REQ-027 When rst_n=0, asynchronously: the state SHALL be IDLE, all four registers 0, operand and command registers 0, res_valid 0, res_data 0, res_zer 0, res_neg 0, and alu_* outputs 0.
REQ-028 cmd_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-029 Reset asserted mid-operation in READ, EXEC or WRITE SHALL abort the command; no res_valid SHALL be produced for it and no register write SHALL occur.

Structure
REQ-030 A shared package SHALL hold the opcode constants (OPC_NEG=000, OPC_INC=001, OPC_ADD=010, OPC_AVG=011, OPC_AND=100, OPC_OR=101, OPC_CAT=110), the 2-bit state encoding, and the data width parameter DW=16.
REQ-031 The 4x16 register file SHALL be one sub-module, alu_regfile, with two combinational read ports and one synchronous write port whose write enable is muxed between the load port and WRITE.
REQ-032 The FSM and the operand/result registers SHALL reside in alu_sequencer.

Verification
REQ-033 Reset, then load r0=0x0005 and r1=0x0003, then command ADD dst=2, a=0, b=1, cin=1 -> alu_a=0x0005 and alu_b=0x0003 in EXEC, res_valid at N+3, res_data=0x0009, zer=0, neg=0, r2=0x0009.
REQ-034 r0=0x0001, command NEG dst=0, a=0 -> res_data=0xFFFF, neg=1, r0=0xFFFF; a following INC dst=0, a=0 -> res_data=0x0000, zer=1.
REQ-035 cmd_valid held high for 3 ADD commands -> cmd_ready pulses every 4th cycle and exactly 3 res_valid pulses occur, 4 cycles apart.
REQ-036 ld_en asserted in EXEC with ld_idx=1 and ld_data=0xAAAA -> r1 unchanged; the same-cycle load in IDLE plus command srca=1 -> operand equals the loaded value.
REQ-037 rst_n pulled low during EXEC -> no res_valid, dst register is 0, and cmd_ready=1 the cycle after release.
REQ-038 Opcode 111 with any operands -> res_data=0x0000, res_zer=1, and the sequence completes in 4 cycles.
